// File: rtl/test_monitor.sv
// Pass/fail/timeout verdict monitor for riscv-tests runs: watches the PC/gp pair
// and tohost stores, latches the first verdict and counts RUN cycles.
module test_monitor #(
    parameter int unsigned          XLEN        = 32,
    parameter logic [XLEN-1:0]      PASS_PC     = 'h44,
    parameter logic [XLEN-1:0]      TOHOST_ADDR = 'h1000,
    parameter int unsigned          MODE        = 2,
    parameter int unsigned          TIMEOUT     = 5000,
    parameter int unsigned          CNT_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [XLEN-1:0]   pc,
    input  logic [XLEN-1:0]   gp,
    input  logic              st_valid,
    input  logic [XLEN-1:0]   st_addr,
    input  logic [XLEN-1:0]   st_data,
    output logic              done,
    output logic              passed,
    output logic              failed,
    output logic              timed_out,
    output logic [XLEN-1:0]   fail_id,
    output logic [CNT_W-1:0]  cycles
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam bit               USE_PC    = (MODE == 0) || (MODE == 2);
    localparam bit               USE_TH    = (MODE == 1) || (MODE == 2);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [XLEN-1:0]  ONE       = XLEN'(1);

    state_t            state_q;
    logic [CNT_W-1:0]  cycles_q, cycles_d;
    logic              done_q, passed_q, failed_q, timed_out_q;
    logic [XLEN-1:0]   fail_id_q;

    logic              pc_evt, th_evt, evt, evt_pass;
    logic [XLEN-1:0]   evt_src;

    always_comb begin
        pc_evt   = USE_PC && (pc == PASS_PC);
        // Stores with bit 0 clear are syscall/proxy requests, not a verdict.
        th_evt   = USE_TH && st_valid && (st_addr == TOHOST_ADDR) && st_data[0];
        evt      = pc_evt || th_evt;
        evt_src  = th_evt ? st_data : gp;
        evt_pass = (evt_src == ONE);
        cycles_d = (cycles_q == CNT_MAX) ? cycles_q : cycles_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cycles_q    <= '0;
            done_q      <= 1'b0;
            passed_q    <= 1'b0;
            failed_q    <= 1'b0;
            timed_out_q <= 1'b0;
            fail_id_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (en) begin
                        state_q  <= S_RUN;
                        cycles_q <= '0;
                    end
                end
                S_RUN: begin
                    cycles_q <= cycles_d;
                    // A detection event on the timeout edge still wins.
                    if (evt) begin
                        state_q   <= S_DONE;
                        done_q    <= 1'b1;
                        passed_q  <= evt_pass;
                        failed_q  <= !evt_pass;
                        fail_id_q <= evt_pass ? '0 : (evt_src >> 1);
                    end else if (cycles_d == TIMEOUT_C) begin
                        state_q     <= S_DONE;
                        done_q      <= 1'b1;
                        timed_out_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_DONE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign done      = done_q;
    assign passed    = passed_q;
    assign failed    = failed_q;
    assign timed_out = timed_out_q;
    assign fail_id   = fail_id_q;
    assign cycles    = cycles_q;

endmodule
